// File: rtl/mpu_tpu_dispatch_pkg.sv
// Shared types and default sizes for the MPU-to-TPU instruction dispatcher.
package mpu_tpu_dispatch_pkg;

  localparam int DEF_IMEM_AW = 10;
  localparam int DEF_INSTR_W = 64;
  localparam int DEF_ISSUE_W = 4;
  localparam int DEF_MAX_OUT = 4;

  typedef logic [DEF_INSTR_W-1:0] instr_t;
  typedef logic [DEF_ISSUE_W-1:0] mpu_issue_no_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } dispatch_state_t;

endpackage

// File: rtl/mpu_tpu_dispatch_issue_tracker.sv
// Outstanding-thread bookkeeping: one bit per issue number plus a live count.
// Decides acceptance of new threads and retires threads on the TPU's Term pulse.
module mpu_tpu_dispatch_issue_tracker
  import mpu_tpu_dispatch_pkg::*;
#(
  parameter int ISSUE_W = DEF_ISSUE_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req,
  input  logic [ISSUE_W-1:0] req_issue_no,
  input  logic               idle,
  input  logic               term,
  input  logic [ISSUE_W-1:0] term_issue_no,
  output logic               ack,
  output logic               commit,
  output logic [ISSUE_W-1:0] commit_issue_no,
  output logic               err_term,
  output logic               any_out
);

  localparam int ENTRIES = 2 ** ISSUE_W;
  localparam int CW      = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic [ENTRIES-1:0] bitmap, bitmap_next;
  logic [CW-1:0]      count, count_next;
  logic               term_hit;

  // Acceptance and Term lookup both use the pre-update bitmap, so a thread
  // retired this cycle can only be re-accepted on the following cycle.
  always_comb begin
    ack         = ~reset & req & idle & ~bitmap[req_issue_no] & (count < MAX_CNT);
    term_hit    = term & bitmap[term_issue_no];
    bitmap_next = bitmap;
    if (term_hit) bitmap_next[term_issue_no] = 1'b0;
    if (ack)      bitmap_next[req_issue_no]  = 1'b1;
    case ({ack, term_hit})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bitmap          <= '0;
      count           <= '0;
      commit          <= 1'b0;
      commit_issue_no <= '0;
      err_term        <= 1'b0;
    end else begin
      bitmap   <= bitmap_next;
      count    <= count_next;
      commit   <= term_hit;
      err_term <= term & ~bitmap[term_issue_no];
      if (term_hit) commit_issue_no <= term_issue_no;
    end
  end

  assign any_out = (count != '0);

endmodule

// File: rtl/mpu_tpu_dispatch.sv
// Streams one thread at a time from thread memory into a TPU request port,
// replaying refused beats and tracking threads until the TPU terminates them.
module mpu_tpu_dispatch
  import mpu_tpu_dispatch_pkg::*;
#(
  parameter int IMEM_AW = DEF_IMEM_AW,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int ISSUE_W = DEF_ISSUE_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                I_En,
  input  logic                I_Thread_Req,
  input  logic [IMEM_AW-1:0]  I_Thread_Addr,
  input  logic [IMEM_AW-1:0]  I_Thread_Len,
  input  logic [ISSUE_W-1:0]  I_Thread_IssueNo,
  output logic                O_Thread_Ack,
  output logic                O_IMem_Re,
  output logic [IMEM_AW-1:0]  O_IMem_Addr,
  input  logic [INSTR_W-1:0]  I_IMem_Data,
  output logic                O_Req,
  output logic [ISSUE_W-1:0]  O_IssueNo,
  output logic [INSTR_W-1:0]  O_Instr,
  input  logic                I_Nack,
  input  logic                I_Term,
  input  logic [ISSUE_W-1:0]  I_Term_IssueNo,
  output logic                O_Commit,
  output logic [ISSUE_W-1:0]  O_Commit_IssueNo,
  output logic                O_Err_Term,
  output logic                O_Busy,
  output dispatch_state_t     O_Dbg_State
);

  dispatch_state_t    state, state_next;
  logic [IMEM_AW-1:0] addr_q, addr_next;
  logic [IMEM_AW-1:0] rem_q, rem_next;
  logic [ISSUE_W-1:0] issue_q, issue_next;
  logic               ack;
  logic               any_out;

  mpu_tpu_dispatch_issue_tracker #(
    .ISSUE_W (ISSUE_W),
    .MAX_OUT (MAX_OUT)
  ) u_tracker (
    .clock           (clock),
    .reset           (reset),
    .req             (I_Thread_Req),
    .req_issue_no    (I_Thread_IssueNo),
    .idle            (state == IDLE),
    .term            (I_Term),
    .term_issue_no   (I_Term_IssueNo),
    .ack             (ack),
    .commit          (O_Commit),
    .commit_issue_no (O_Commit_IssueNo),
    .err_term        (O_Err_Term),
    .any_out         (any_out)
  );

  // TPU handshake: a beat transfers in any cycle where O_Req is high and
  // I_Nack is low. A refused beat is re-read and presented again next cycle;
  // dropping I_En returns to FETCH so the current beat is re-primed on resume.
  always_comb begin
    state_next  = state;
    addr_next   = addr_q;
    rem_next    = rem_q;
    issue_next  = issue_q;
    O_IMem_Re   = 1'b0;
    O_IMem_Addr = addr_q;
    O_Req       = 1'b0;
    case (state)
      IDLE: begin
        if (ack) begin
          addr_next  = I_Thread_Addr;
          rem_next   = I_Thread_Len;
          issue_next = I_Thread_IssueNo;
          state_next = FETCH;
        end
      end
      FETCH: begin
        O_IMem_Re  = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        O_Req = I_En;
        if (!I_En) begin
          state_next = FETCH;
        end else if (I_Nack) begin
          O_IMem_Re = 1'b1;
        end else if (rem_q != '0) begin
          addr_next   = addr_q + 1'b1;
          rem_next    = rem_q - 1'b1;
          O_IMem_Re   = 1'b1;
          O_IMem_Addr = addr_q + 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      issue_q <= '0;
    end else begin
      state   <= state_next;
      addr_q  <= addr_next;
      rem_q   <= rem_next;
      issue_q <= issue_next;
    end
  end

  assign O_Thread_Ack = ack;
  assign O_IssueNo    = issue_q;
  assign O_Instr      = I_IMem_Data;
  assign O_Busy       = (state != IDLE) | any_out;
  assign O_Dbg_State  = state;

endmodule
